// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and owner tags
// used to remember which requester was granted most recently.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        HOST = 2'd2
    } arb_state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port dat_mem between the core
// load/store path and the host loader, with a bounded host burst lock.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
);

    localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CW-1:0] LOCK_TOP = CW'(MAX_LOCK - 1);

    arb_state_t    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_hold;
    logic          core_rvalid_q, host_rvalid_q;
    logic [DW-1:0] core_rdata_q, host_rdata_q;

    assign core_gnt    = (state_q == CORE) && core_req;
    assign host_gnt    = (state_q == HOST) && host_req;
    assign core_stall  = core_req && !core_gnt;
    assign core_rvalid = core_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

    // Host keeps the memory only while the core has not yet waited MAX_LOCK beats.
    assign lock_hold = host_lock && host_req && (!core_req || (lock_cnt_q < LOCK_TOP));

    always_comb begin
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_dat_in = '0;
        if (core_gnt) begin
            mem_wr_en  = core_we;
            mem_addr   = core_addr;
            mem_dat_in = core_wdata;
        end else if (host_gnt) begin
            mem_wr_en  = host_we;
            mem_addr   = host_addr;
            mem_dat_in = host_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (core_req && host_req) state_d = (last_q == OWN_HOST) ? CORE : HOST;
                else if (core_req)        state_d = CORE;
                else if (host_req)        state_d = HOST;
                else                      state_d = IDLE;
            end
            CORE: begin
                if (host_req)      state_d = HOST;
                else if (core_req) state_d = CORE;
                else               state_d = IDLE;
            end
            HOST: begin
                if (lock_hold)     state_d = HOST;
                else if (core_req) state_d = CORE;
                else if (host_req) state_d = HOST;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (core_gnt)      last_d = OWN_CORE;
        else if (host_gnt) last_d = OWN_HOST;

        lock_cnt_d = lock_cnt_q;
        if (!core_req || (state_d != HOST))
            lock_cnt_d = '0;
        else if (host_gnt && host_lock && (lock_cnt_q != LOCK_TOP))
            lock_cnt_d = lock_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= OWN_HOST;
            lock_cnt_q    <= '0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            lock_cnt_q    <= lock_cnt_d;
            core_rvalid_q <= core_gnt && !core_we;
            host_rvalid_q <= host_gnt && !host_we;
            if (core_gnt && !core_we) core_rdata_q <= mem_dat_out;
            if (host_gnt && !host_we) host_rdata_q <= mem_dat_out;
        end
    end

    // A requester may not withdraw before it has been served.
    a_core_hold: assert property (@(posedge clk) disable iff (reset)
        core_req && !core_gnt |=> core_req);
    a_host_hold: assert property (@(posedge clk) disable iff (reset)
        host_req && !host_gnt |=> host_req);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed request streams, a dat_mem model,
// and a negedge monitor that checks grants and read returns against queues.
module tb_dmem_arbiter;

    typedef struct packed {
        logic       own;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       core_req = 1'b0, core_we = 1'b0;
    logic [7:0] core_addr = '0, core_wdata = '0;
    logic       core_gnt, core_rvalid, core_stall;
    logic [7:0] core_rdata;
    logic       host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_addr, mem_dat_in, mem_dat_out;

    logic [7:0] mem [256];

    beat_t      cq[$], hq[$], exp_g[$];
    logic [7:0] exp_cr[$], exp_hr[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(8)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
        .mem_dat_out(mem_dat_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : a + 8'h40;
    endfunction

    // dat_mem model: combinational read, write at the grant edge
    assign mem_dat_out = mem[mem_addr];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_dat_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event with no expectation queued", name);
    endtask

    task automatic apply();
        core_req   = (cq.size() != 0);
        core_we    = core_req ? cq[0].we    : 1'b0;
        core_addr  = core_req ? cq[0].addr  : 8'h00;
        core_wdata = core_req ? cq[0].wdata : 8'h00;
        host_req   = (hq.size() != 0);
        host_we    = host_req ? hq[0].we    : 1'b0;
        host_addr  = host_req ? hq[0].addr  : 8'h00;
        host_wdata = host_req ? hq[0].wdata : 8'h00;
    endtask

    // Advance one cycle; retire each requester's head beat once it was granted.
    task automatic step();
        logic gc, gh;
        @(negedge clk);
        gc = core_gnt;
        gh = host_gnt;
        @(posedge clk);
        #1;
        if (gc && cq.size() != 0) cq.delete(0);
        if (gh && hq.size() != 0) hq.delete(0);
        apply();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic core_beat(input logic we, input logic [7:0] a, input logic [7:0] d);
        cq.push_back('{own: 1'b0, we: we, addr: a, wdata: d});
    endtask

    task automatic host_beat(input logic we, input logic [7:0] a, input logic [7:0] d);
        hq.push_back('{own: 1'b1, we: we, addr: a, wdata: d});
    endtask

    task automatic expect_gnt(input logic own, input logic we, input logic [7:0] a,
                              input logic [7:0] d);
        exp_g.push_back('{own: own, we: we, addr: a, wdata: d});
    endtask

    // Monitor
    initial begin
        beat_t g;
        forever begin
            @(negedge clk);
            if (core_gnt || host_gnt) begin
                chk("gnt_exclusive", 32'(core_gnt & host_gnt), 0);
                if (exp_g.size() == 0) begin
                    fail_evt("gnt_unexpected");
                end else begin
                    g = exp_g.pop_front();
                    chk("gnt_owner", 32'(host_gnt), 32'(g.own));
                    chk("gnt_addr", 32'(mem_addr), 32'(g.addr));
                    chk("gnt_wr_en", 32'(mem_wr_en), 32'(g.we));
                    if (g.we) chk("gnt_wdata", 32'(mem_dat_in), 32'(g.wdata));
                end
            end
            if (core_rvalid) begin
                if (exp_cr.size() == 0) fail_evt("core_rvalid_unexpected");
                else chk("core_rdata", 32'(core_rdata), 32'(exp_cr.pop_front()));
            end
            if (host_rvalid) begin
                if (exp_hr.size() == 0) fail_evt("host_rvalid_unexpected");
                else chk("host_rdata", 32'(host_rdata), 32'(exp_hr.pop_front()));
            end
        end
    end

    initial begin
        // 1: reset with random request activity
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            core_req   = 1'($urandom_range(0, 1));
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = 8'($urandom_range(0, 255));
            core_wdata = 8'($urandom_range(0, 255));
            host_req   = 1'($urandom_range(0, 1));
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 8'($urandom_range(0, 255));
            host_wdata = 8'($urandom_range(0, 255));
            host_lock  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_ctrl", {core_gnt, host_gnt, core_rvalid, host_rvalid, mem_wr_en}, 0);
            chk("rst_rdata", {core_rdata, host_rdata}, 0);
            chk("rst_mem_bus", {mem_addr, mem_dat_in}, 0);
        end
        @(posedge clk);
        #1;
        host_lock = 1'b0;
        apply();
        reset = 1'b0;
        idle(2);

        // 3: both requesters held -> alternate C,H,C,H starting with core
        for (int i = 0; i < 4; i++) begin
            core_beat(1'b0, 8'(i), 8'h00);
            exp_cr.push_back(8'h40 + 8'(i));
            host_beat(1'b1, 8'h50 + 8'(i), 8'hC0 + 8'(i));
            expect_gnt(1'b0, 1'b0, 8'(i), 8'h00);
            expect_gnt(1'b1, 1'b1, 8'h50 + 8'(i), 8'hC0 + 8'(i));
        end
        apply();
        #1;
        chk("t3_stall_idle", 32'(core_stall), 1);
        step();
        #1;
        chk("t3_first_core", 32'(core_gnt), 1);
        chk("t3_nostall_gnt", 32'(core_stall), 0);
        step();
        #1;
        chk("t3_second_host", 32'(host_gnt), 1);
        chk("t3_stall_host", 32'(core_stall), 1);
        step();
        #1;
        chk("t3_third_core", 32'(core_gnt), 1);
        idle(8);

        // 2: single core read latency
        core_beat(1'b0, 8'h10, 8'h00);
        expect_gnt(1'b0, 1'b0, 8'h10, 8'h00);
        exp_cr.push_back(8'hA5);
        apply();
        #1;
        chk("t2_gnt_n", 32'(core_gnt), 0);
        chk("t2_stall_n", 32'(core_stall), 1);
        step();
        #1;
        chk("t2_gnt_n1", 32'(core_gnt), 1);
        step();
        #1;
        chk("t2_rvalid_n2", 32'(core_rvalid), 1);
        chk("t2_rdata_n2", 32'(core_rdata), 32'h A5);
        step();
        #1;
        chk("t2_rvalid_n3", 32'(core_rvalid), 0);
        chk("t2_rdata_hold", 32'(core_rdata), 32'h A5);
        idle(2);

        // 4: host lock bounded to 8 beats while core waits
        host_lock = 1'b1;
        for (int i = 0; i < 12; i++) host_beat(1'b1, 8'h60 + 8'(i), 8'h80 + 8'(i));
        core_beat(1'b0, 8'h10, 8'h00);
        core_beat(1'b0, 8'h60, 8'h00);
        for (int i = 0; i < 8; i++) expect_gnt(1'b1, 1'b1, 8'h60 + 8'(i), 8'h80 + 8'(i));
        expect_gnt(1'b0, 1'b0, 8'h10, 8'h00);
        for (int i = 8; i < 12; i++) expect_gnt(1'b1, 1'b1, 8'h60 + 8'(i), 8'h80 + 8'(i));
        expect_gnt(1'b0, 1'b0, 8'h60, 8'h00);
        exp_cr.push_back(8'hA5);
        exp_cr.push_back(8'h80);
        apply();
        idle(8);
        #1;
        chk("t4_eighth_host", 32'(host_gnt), 1);
        step();
        #1;
        chk("t4_core_breaks_lock", 32'(core_gnt), 1);
        step();
        #1;
        chk("t4_host_resumes", 32'(host_gnt), 1);
        idle(8);
        host_lock = 1'b0;
        apply();
        idle(2);

        // 5: host read, host write 0x3C@0x20, then core read of 0x20
        host_beat(1'b0, 8'h10, 8'h00);
        host_beat(1'b1, 8'h20, 8'h3C);
        exp_hr.push_back(8'hA5);
        expect_gnt(1'b1, 1'b0, 8'h10, 8'h00);
        expect_gnt(1'b1, 1'b1, 8'h20, 8'h3C);
        expect_gnt(1'b0, 1'b0, 8'h20, 8'h00);
        exp_cr.push_back(8'h3C);
        apply();
        step();
        step();
        core_beat(1'b0, 8'h20, 8'h00);
        apply();
        step();
        step();
        #1;
        chk("t5_core_rdata", 32'(core_rdata), 32'h3C);
        chk("t5_host_rdata_kept", 32'(host_rdata), 32'h A5);
        idle(3);

        // 6: reset during a locked host read burst
        host_lock = 1'b1;
        for (int i = 0; i < 4; i++) host_beat(1'b0, 8'h30 + 8'(i), 8'h00);
        expect_gnt(1'b1, 1'b0, 8'h30, 8'h00);
        expect_gnt(1'b1, 1'b0, 8'h31, 8'h00);
        exp_hr.push_back(8'h70);
        apply();
        step();
        step();
        step();
        #1;
        chk("t6_gnt_before_rst", 32'(host_gnt), 1);
        chk("t6_rdata_before_rst", {host_rvalid, host_rdata}, 32'h171);
        reset = 1'b1;
        #1;
        chk("t6_gnt_drop", {core_gnt, host_gnt, mem_wr_en}, 0);
        chk("t6_rvalid_drop", 32'(host_rvalid), 0);
        chk("t6_rdata_clear", 32'(host_rdata), 0);
        cq.delete();
        hq.delete();
        host_lock = 1'b0;
        apply();
        @(posedge clk);
        @(posedge clk);
        #1;
        core_beat(1'b0, 8'h40, 8'h00);
        host_beat(1'b0, 8'h41, 8'h00);
        expect_gnt(1'b0, 1'b0, 8'h40, 8'h00);
        expect_gnt(1'b1, 1'b0, 8'h41, 8'h00);
        exp_cr.push_back(8'h80);
        exp_hr.push_back(8'h81);
        reset = 1'b0;
        apply();
        #1;
        chk("t6_idle_after_rst", {core_gnt, host_gnt}, 0);
        step();
        #1;
        chk("t6_core_wins_tie", 32'(core_gnt), 1);
        idle(5);

        chk("left_gnt", exp_g.size(), 0);
        chk("left_core_rd", exp_cr.size(), 0);
        chk("left_host_rd", exp_hr.size(), 0);
        chk("left_reqs", cq.size() + hq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
